// File: rtl/keypad_scanner_pkg.sv
// Shared types and the key map for the 4x4 keypad scanner.
// The FSM state and frame-class encodings live here so the top and the bench agree.
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE  = 2'd0,
      FC_ONE   = 2'd1,
      FC_MULTI = 2'd2
   } frame_class_t;

   // Nibble (r*4 + c) holds the hex legend printed on key (row r, column c).
   localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

   // Frame bits are laid out column-major ({col, row}); the key map is row-major.
   function automatic logic [3:0] key_lookup(input logic [3:0] frame_bit);
      logic [5:0] base;
      base = {frame_bit[1:0], frame_bit[3:2], 2'b00};
      return KEY_MAP[base +: 4];
   endfunction

endpackage

// File: rtl/keypad_scanner_col_scan.sv
// Column driver for the keypad: row synchronizer, dwell counter, column rotation
// and the 16-bit raw frame register (active-low, bit 4c+r).
module keypad_scanner_col_scan #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        srst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [15:0] frame,
   output logic        eof
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   logic [3:0]    sync1_reg;
   logic [3:0]    sync2_reg;
   logic [DW-1:0] dwell_reg;
   logic [1:0]    col_idx_reg;
   logic [3:0]    col_reg;
   logic          eof_reg;
   logic          tick;

   assign tick = (dwell_reg == DWELL_LAST);

   always_ff @(posedge clk) begin
      if (srst) begin
         sync1_reg   <= 4'hF;
         sync2_reg   <= 4'hF;
         dwell_reg   <= '0;
         col_idx_reg <= 2'd0;
         col_reg     <= 4'b1110;
         eof_reg     <= 1'b0;
      end else begin
         sync1_reg <= row;
         sync2_reg <= sync1_reg;
         eof_reg   <= tick && (col_idx_reg == 2'd3);
         if (tick) begin
            dwell_reg   <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
            col_reg     <= {col_reg[2:0], col_reg[3]};
         end else begin
            dwell_reg <= dwell_reg + DW'(1);
         end
      end
   end

   // One slice per column; a slice is only overwritten while its column is driven.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slice
         logic [3:0] slice_reg;
         always_ff @(posedge clk) begin
            if (srst) begin
               slice_reg <= 4'hF;
            end else if (tick && (col_idx_reg == 2'(gi))) begin
               slice_reg <= sync2_reg;
            end
         end
         assign frame[4*gi +: 4] = slice_reg;
      end
   endgenerate

   assign col = col_reg;
   assign eof = eof_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: classifies each completed frame and debounces press/release
// into a single-cycle key event plus a held flag.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_FRAMES);

   logic [15:0]  frame;
   logic         eof;
   logic [4:0]   press_count;
   logic [3:0]   press_bit;
   logic [3:0]   hit_code;
   frame_class_t frame_class;

   state_t        state_reg, state_next;
   logic [3:0]    cand_reg, cand_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] cnt_inc;
   logic [3:0]    code_reg, code_next;
   logic          valid_reg, valid_next;
   logic          held_reg, held_next;

   keypad_scanner_col_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_col_scan (
      .clk   (Clk),
      .srst  (Rst),
      .row   (Row),
      .col   (Col),
      .frame (frame),
      .eof   (eof)
   );

   always_comb begin
      press_count = '0;
      press_bit   = '0;
      for (int i = 0; i < 16; i++) begin
         if (!frame[i]) begin
            press_count = press_count + 5'd1;
            press_bit   = 4'(i);
         end
      end
      if (press_count == 5'd0) begin
         frame_class = FC_NONE;
      end else if (press_count == 5'd1) begin
         frame_class = FC_ONE;
      end else begin
         frame_class = FC_MULTI;
      end
   end

   assign hit_code = key_lookup(press_bit);
   assign cnt_inc  = cnt_reg + CNT_ONE;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg <= ST_IDLE;
         cand_reg  <= 4'h0;
         cnt_reg   <= '0;
         code_reg  <= 4'h0;
         valid_reg <= 1'b0;
         held_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cand_reg  <= cand_next;
         cnt_reg   <= cnt_next;
         code_reg  <= code_next;
         valid_reg <= valid_next;
         held_reg  <= held_next;
      end
   end

   // The candidate is kept as its hex code; the map is one-to-one so this is lossless.
   always_comb begin
      state_next = state_reg;
      cand_next  = cand_reg;
      cnt_next   = cnt_reg;
      code_next  = code_reg;
      valid_next = 1'b0;
      held_next  = held_reg;
      if (eof) begin
         case (state_reg)
            ST_IDLE: begin
               if (frame_class == FC_ONE) begin
                  cand_next = hit_code;
                  cnt_next  = CNT_ONE;
                  if (DEBOUNCE_FRAMES == 1) begin
                     state_next = ST_PRESSED;
                     code_next  = hit_code;
                     valid_next = 1'b1;
                     held_next  = 1'b1;
                  end else begin
                     state_next = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (frame_class == FC_ONE && hit_code == cand_reg) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == CNT_ACCEPT) begin
                     state_next = ST_PRESSED;
                     code_next  = cand_reg;
                     valid_next = 1'b1;
                     held_next  = 1'b1;
                  end
               end else if (frame_class == FC_ONE) begin
                  cand_next = hit_code;
                  cnt_next  = CNT_ONE;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               if (frame_class == FC_NONE) begin
                  cnt_next = CNT_ONE;
                  if (DEBOUNCE_FRAMES == 1) begin
                     state_next = ST_IDLE;
                     held_next  = 1'b0;
                  end else begin
                     state_next = ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               if (frame_class == FC_NONE) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == CNT_ACCEPT) begin
                     state_next = ST_IDLE;
                     held_next  = 1'b0;
                  end
               end else begin
                  state_next = ST_PRESSED;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign key_code  = code_reg;
   assign key_valid = valid_reg;
   assign key_held  = held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives Row from Col, and a frame-level
// reference predicts Col, key_valid, key_code and key_held on every cycle.
module tb_keypad_scanner;

   localparam int SCAN_DIV        = 8;
   localparam int DEBOUNCE_FRAMES = 3;
   localparam int FRAME           = 4 * SCAN_DIV;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [3:0] Row;
   logic [3:0] Col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   // Pressed keys, bit index r*4 + c.
   logic [15:0] key_mask = '0;

   int tests = 0;
   int fails = 0;
   int pulses = 0;

   always #5 Clk = ~Clk;

   // Physical keypad: a row reads low when its key in the driven column is pressed.
   always_comb begin
      Row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (!Col[c]) begin
            for (int r = 0; r < 4; r++) begin
               if (key_mask[r*4 + c]) Row[r] = 1'b0;
            end
         end
      end
   end

   keypad_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Row       (Row),
      .Col       (Col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_CONFIRM, M_DOWN, M_UP} mphase_t;

   logic [3:0]  key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'h0, 4'hF, 4'hE, 4'hD};
   int          n = 0;
   logic [15:0] mask_at_prev1 = '0;
   logic [15:0] mask_at_prev2 = '0;
   logic [15:0] acc = '0;
   logic [15:0] done_frame = '0;
   bit          frame_ready = 1'b0;
   mphase_t     ph = M_IDLE;
   int          m_cand = 0;
   int          m_cnt = 0;
   logic [3:0]  exp_code = 4'h0;
   logic        exp_valid = 1'b0;
   logic        exp_held = 1'b0;

   task automatic accept_key();
      ph        = M_DOWN;
      exp_code  = key_map[m_cand];
      exp_valid = 1'b1;
      exp_held  = 1'b1;
   endtask

   task automatic apply_frame(input logic [15:0] f);
      int cnt_keys;
      int idx;
      cnt_keys = $countones(f);
      idx = 0;
      for (int i = 0; i < 16; i++) if (f[i]) idx = i;
      case (ph)
         M_IDLE: if (cnt_keys == 1) begin
            m_cand = idx; m_cnt = 1;
            if (m_cnt == DEBOUNCE_FRAMES) accept_key(); else ph = M_CONFIRM;
         end
         M_CONFIRM: if (cnt_keys == 1 && idx == m_cand) begin
            m_cnt++;
            if (m_cnt == DEBOUNCE_FRAMES) accept_key();
         end else if (cnt_keys == 1) begin
            m_cand = idx; m_cnt = 1;
         end else begin
            ph = M_IDLE;
         end
         M_DOWN: if (cnt_keys == 0) begin
            m_cnt = 1;
            if (m_cnt == DEBOUNCE_FRAMES) begin ph = M_IDLE; exp_held = 1'b0; end
            else ph = M_UP;
         end
         M_UP: if (cnt_keys == 0) begin
            m_cnt++;
            if (m_cnt == DEBOUNCE_FRAMES) begin ph = M_IDLE; exp_held = 1'b0; end
         end else begin
            ph = M_DOWN;
         end
      endcase
   endtask

   // Advance the model by one clock edge. Column c is sampled at edge n (n a multiple
   // of SCAN_DIV) with the row levels seen two edges earlier.
   task automatic model_edge();
      int c;
      if (Rst) begin
         n = 0; acc = '0; frame_ready = 1'b0; ph = M_IDLE; m_cnt = 0;
         exp_code = 4'h0; exp_valid = 1'b0; exp_held = 1'b0;
      end else begin
         n++;
         exp_valid = 1'b0;
         if (frame_ready) begin
            frame_ready = 1'b0;
            apply_frame(done_frame);
         end
         if (n % SCAN_DIV == 0) begin
            c = ((n / SCAN_DIV) - 1) % 4;
            for (int r = 0; r < 4; r++) acc[r*4 + c] = mask_at_prev2[r*4 + c];
            if (c == 3) begin
               done_frame  = acc;
               frame_ready = 1'b1;
            end
         end
      end
      mask_at_prev2 = mask_at_prev1;
      mask_at_prev1 = key_mask;
   endtask

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic step(input int cycles);
      logic [3:0] one_hot;
      for (int k = 0; k < cycles; k++) begin
         @(posedge Clk);
         model_edge();
         #1;
         one_hot = 4'b0001 << ((n / SCAN_DIV) % 4);
         if (key_valid === 1'b1) pulses++;
         check("col", {12'h0, Col}, {12'h0, ~one_hot});
         check("key_valid", {15'h0, key_valid}, {15'h0, exp_valid});
         check("key_held", {15'h0, key_held}, {15'h0, exp_held});
         check("key_code", {12'h0, key_code}, {12'h0, exp_code});
      end
   endtask

   task automatic align_eof();
      for (int k = 0; k < FRAME && (n % FRAME) != 0; k++) step(1);
   endtask

   initial begin
      int p0;
      int sel;

      // 1. reset state and column stepping
      Rst = 1'b1;
      step(3);
      check("rst_col", {12'h0, Col}, 16'h000E);
      check("rst_code", {12'h0, key_code}, 16'h0);
      check("rst_valid", {15'h0, key_valid}, 16'h0);
      check("rst_held", {15'h0, key_held}, 16'h0);
      Rst = 1'b0;
      step(8);
      check("col_after_8", {12'h0, Col}, 16'h000D);
      step(16);
      check("col_after_24", {12'h0, Col}, 16'h0007);

      // 2. steady press of '5', then release
      p0 = pulses;
      key_mask = 16'h0001 << 5;
      step(6 * FRAME);
      check("t2_pulses", 16'(pulses - p0), 16'd1);
      check("t2_code", {12'h0, key_code}, 16'h0005);
      check("t2_held", {15'h0, key_held}, 16'h1);
      key_mask = '0;
      step(6 * FRAME);
      check("t2_released", {15'h0, key_held}, 16'h0);

      // 3. bouncing 'E', then stable
      align_eof();
      p0 = pulses;
      for (int i = 0; i < 20; i++) begin
         key_mask = (i % 2 == 0) ? (16'h0001 << 14) : 16'h0;
         step(5);
      end
      check("t3_bounce_pulses", 16'(pulses - p0), 16'd0);
      key_mask = 16'h0001 << 14;
      step(6 * FRAME);
      check("t3_pulses", 16'(pulses - p0), 16'd1);
      check("t3_code", {12'h0, key_code}, 16'h000E);
      key_mask = '0;
      step(6 * FRAME);

      // 4. two keys together never produce an event
      p0 = pulses;
      key_mask = 16'h0003;
      step(10 * FRAME);
      check("t4_pulses", 16'(pulses - p0), 16'd0);
      check("t4_held", {15'h0, key_held}, 16'h0);
      key_mask = '0;
      step(4 * FRAME);

      // 5. long hold of 'D', short gap, full release, re-press
      p0 = pulses;
      key_mask = 16'h0001 << 15;
      step(20 * FRAME);
      check("t5_hold_pulses", 16'(pulses - p0), 16'd1);
      check("t5_code", {12'h0, key_code}, 16'h000D);
      key_mask = '0;
      step(FRAME);
      key_mask = 16'h0001 << 15;
      step(6 * FRAME);
      check("t5_gap_pulses", 16'(pulses - p0), 16'd1);
      check("t5_gap_held", {15'h0, key_held}, 16'h1);
      key_mask = '0;
      step(6 * FRAME);
      check("t5_release_held", {15'h0, key_held}, 16'h0);
      key_mask = 16'h0001 << 15;
      step(6 * FRAME);
      check("t5_repress_pulses", 16'(pulses - p0), 16'd2);
      check("t5_repress_code", {12'h0, key_code}, 16'h000D);
      key_mask = '0;
      step(6 * FRAME);

      // 6. reset while debouncing 'A' with two matching frames seen
      align_eof();
      p0 = pulses;
      key_mask = 16'h0001 << 3;
      step(2 * FRAME + 6);
      check("t6_pre_rst_pulses", 16'(pulses - p0), 16'd0);
      Rst = 1'b1;
      step(1);
      Rst = 1'b0;
      step(3 * FRAME);
      check("t6_no_early_pulse", 16'(pulses - p0), 16'd0);
      step(FRAME);
      check("t6_pulses", 16'(pulses - p0), 16'd1);
      check("t6_code", {12'h0, key_code}, 16'h000A);
      key_mask = '0;
      step(6 * FRAME);

      // 7. random presses, chords, gaps and the occasional reset
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel <= 5) key_mask = 16'h0001 << $urandom_range(0, 15);
         else if (sel <= 7) key_mask = (16'h0001 << $urandom_range(0, 15)) |
                                       (16'h0001 << $urandom_range(0, 15));
         else key_mask = '0;
         if ($urandom_range(0, 19) == 0) begin
            Rst = 1'b1;
            step(1);
            Rst = 1'b0;
         end
         step(int'($urandom_range(5, 5 * FRAME)));
      end
      key_mask = '0;
      step(6 * FRAME);
      check("end_held", {15'h0, key_held}, 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
